// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// rx is brought into the clk domain by a 2-FF synchroniser, and the framing FSM
// samples each bit near its centre. Good bytes are pushed in the stop-bit
// sample cycle. Firmware drains the FIFO through a valid/ready pop port.
// Optional build macro: UART_RX_PARITY_EN adds one even-parity bit per frame
// and a sticky parity_err output.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [7:0]         rd_data,
  output logic [FIFO_AW:0]   level,
  output logic               overrun,
  output logic               frame_err,
  input  logic               clear_err,
`ifdef UART_RX_PARITY_EN
  output logic               parity_err,
`endif
  output logic               busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CPB_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'((CLKS_PER_BIT / 2) - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [FIFO_AW:0] DEPTH_L   = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] LEVEL_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

`ifdef UART_RX_PARITY_EN
  // Even parity: the eight data bits plus the parity bit carry an even count of ones.
  function automatic logic parity_bad(input logic [7:0] data, input logic par_bit);
    return ^{data, par_bit};
  endfunction
`endif

  // Synchroniser and framing state
  logic              rx_meta_q;
  logic              rx_s_q;
  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              stop_sample_s;

  // FIFO state
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]  level_q, level_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;

  logic              full_s;
  logic              good_frame_s;
  logic              push_s;
  logic              pop_s;
  logic              overrun_set_s;
  logic              frame_err_set_s;

`ifdef UART_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
  logic              parity_err_q, parity_err_d;
  logic              parity_set_s;
`endif

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Framing FSM: locate the start-bit centre, then sample every CLKS_PER_BIT cycles.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    stop_sample_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d     = par_bad_q;
    parity_set_s  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          // A line that is high again at mid start bit was only a glitch.
          if (!rx_s_q) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == CPB_M1) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CPB_M1) begin
          cnt_d        = '0;
          par_bad_d    = parity_bad(shift_q, rx_s_q);
          parity_set_s = parity_bad(shift_q, rx_s_q);
          state_d      = STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CPB_M1) begin
          cnt_d         = '0;
          stop_sample_s = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Framing FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Frame outcome and FIFO handshake. A pop in the same cycle frees the slot for a push.
  always_comb begin
    full_s          = (level_q == DEPTH_L);
    pop_s           = (level_q != '0) && rd_ready;
    frame_err_set_s = stop_sample_s && !rx_s_q;
`ifdef UART_RX_PARITY_EN
    good_frame_s    = stop_sample_s && rx_s_q && !par_bad_q;
`else
    good_frame_s    = stop_sample_s && rx_s_q;
`endif
    push_s          = good_frame_s && (!full_s || pop_s);
    overrun_set_s   = good_frame_s && full_s && !pop_s;
  end

  // Next-state for pointers, occupancy and sticky flags (a set beats a same-cycle clear).
  always_comb begin
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
    overrun_d   = overrun_set_s   || (overrun_q   && !clear_err);
    frame_err_d = frame_err_set_s || (frame_err_q && !clear_err);
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_set_s   || (parity_err_q && !clear_err);
`endif
  end

  // FIFO control and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity tracking: per-frame mismatch marker plus the sticky output flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

  // Byte storage; contents only become visible through rd_data once counted in level.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign rd_valid  = (level_q != '0);
  assign rd_data   = (level_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign level     = level_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: drives 8N1 frames on rx and predicts the FIFO
// contents and flags with a queue model. A negedge monitor compares every
// popped byte with the head of that queue.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int HALF  = CPB / 2;
  // Frame-relative cycle whose closing edge is the receiver's stop-bit sample
  // (2 sync flops + 1 IDLE->START edge + HALF + 9 bit periods, minus one).
  localparam int STOP_CYC = 3 + HALF + 9 * CPB - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          rd_ready = 1'b0;
  logic          clear_err = 1'b0;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic [AW:0]   level;
  logic          overrun;
  logic          frame_err;
  logic          busy;

  int            total = 0;
  int            passed = 0;
  logic [7:0]    exp_q[$];
  logic          exp_overrun = 1'b0;
  logic          exp_frame_err = 1'b0;
  logic          busy_seen = 1'b0;
  logic [7:0]    mon_exp;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
    .overrun(overrun), .frame_err(frame_err), .clear_err(clear_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every handshake pops the oldest expected byte.
  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (rst_n && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL pop_extra: got 0x%0h, expected no entry", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("pop_data", 32'(rd_data), 32'(mon_exp));
      end
    end
  end

  task automatic check_state(input string tag);
    chk({tag, "_level"},     32'(level),     32'(exp_q.size()));
    chk({tag, "_rd_valid"},  32'(rd_valid),  32'(exp_q.size() != 0));
    chk({tag, "_overrun"},   32'(overrun),   32'(exp_overrun));
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(exp_frame_err));
    if (exp_q.size() != 0) chk({tag, "_head"}, 32'(rd_data), 32'(exp_q[0]));
  endtask

  // One frame, one clock per loop pass. Optionally pops exactly in the stop
  // sample cycle, or asserts reset at cycle abort_at.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input bit pop_at_stop, input int abort_at);
    logic [9:0] bits;
    bit aborted;
    bits = {stop_bit, b, 1'b0};
    aborted = 1'b0;
    for (int c = 0; c < 10 * CPB; c++) begin
      @(posedge clk); #1;
      if (c == abort_at) begin
        rst_n = 1'b0;
        rx = 1'b1;
        rd_ready = 1'b0;
        aborted = 1'b1;
        break;
      end
      rx = bits[c / CPB];
      if (pop_at_stop) rd_ready = (c == STOP_CYC);
    end
    rx = 1'b1;
    if (!aborted) begin
      if (!stop_bit) exp_frame_err = 1'b1;
      else if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_overrun = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    rd_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      @(posedge clk); #1;
      if (!rd_valid) begin
        done = 1'b1;
        break;
      end
    end
    rd_ready = 1'b0;
    chk("drain_done", 32'(done), 32'(1));
    chk("drain_level", 32'(level), 32'(0));
    chk("drain_model_empty", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
  endtask

  task automatic pop_n(input int k);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    repeat (k) @(posedge clk);
    #1;
    rd_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    exp_overrun = 1'b0;
    exp_frame_err = 1'b0;
  endtask

  // Hard stop in case the run wedges.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       sb;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_valid",  32'(rd_valid),  32'(0));
    chk("rst_rd_data",   32'(rd_data),   32'(8'h00));
    chk("rst_level",     32'(level),     32'(0));
    chk("rst_overrun",   32'(overrun),   32'(0));
    chk("rst_frame_err", 32'(frame_err), 32'(0));
    chk("rst_busy",      32'(busy),      32'(0));
    rst_n = 1'b1;
    idle(5);

    // Single bytes
    send_frame(8'h00, 1'b1, 1'b0, -1);
    idle(4);
    check_state("byte00");
    drain();
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    idle(4);
    check_state("byteA5");
    drain();
    chk("after_pop_rd_valid", 32'(rd_valid), 32'(0));

    // 17 back-to-back frames: the 17th overruns
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 1'b0, -1);
    idle(4);
    check_state("b2b17");
    drain();
    pulse_clear();
    check_state("b2b_cleared");

    // Full FIFO with a pop in the same cycle as the stop-bit push
    for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b1, 1'b0, -1);
    send_frame(8'hE7, 1'b1, 1'b1, -1);
    idle(4);
    check_state("full_pop_push");
    drain();

    // Short low glitch on the idle line
    busy_seen = 1'b0;
    @(posedge clk); #1;
    rx = 1'b0;
    idle(CPB / 4);
    rx = 1'b1;
    idle(3 * CPB);
    chk("glitch_busy_pulse", 32'(busy_seen), 32'(1));
    chk("glitch_busy_low",   32'(busy),      32'(0));
    check_state("glitch");

    // Stop bit forced low, then a good frame
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    idle(3 * CPB);
    check_state("stop_low");
    send_frame(8'h55, 1'b1, 1'b0, -1);
    idle(4);
    check_state("after_ferr");
    drain();

    // Reset in the middle of the data bits of 8'hFF (frame_err still set here)
    send_frame(8'hFF, 1'b1, 1'b0, 3 + HALF + 3 * CPB);
    exp_q.delete();
    exp_overrun = 1'b0;
    exp_frame_err = 1'b0;
    idle(2);
    chk("midrst_busy", 32'(busy), 32'(0));
    check_state("midrst");
    rst_n = 1'b1;
    idle(5);
    send_frame(8'h81, 1'b1, 1'b0, -1);
    idle(4);
    check_state("post_rst");
    drain();

    // Randomised traffic: bad stop bits, gaps, partial drains and clears
    for (int i = 0; i < 30; i++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      send_frame(b, sb, 1'b0, -1);
      if (!sb) idle(2 * CPB);
      else idle($urandom_range(0, 12));
      check_state("rand");
      if ($urandom_range(0, 3) == 0) pop_n($urandom_range(1, 10));
      if ($urandom_range(0, 5) == 0) pulse_clear();
    end
    drain();
    pulse_clear();
    check_state("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- User-project UART receiver: de-serialises 8N1 frames arriving on mprj_io[5], driven by the bench UART transmitter, and buffers bytes in a small FIFO.
- Firmware drains the FIFO through the Wishbone/UART register block via a valid/ready pop interface.
- Sits directly downstream of the bench transmitter's serial line and upstream of the UART register slave.

Parameters:
- CLKS_PER_BIT, 4167, clock cycles per bit (40 MHz / 9600 baud); legal range >= 8.
- FIFO_DEPTH, 16, entries; power of two, >= 2.
- FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  serial input, idle high, asynchronous to clk
- rd_ready  in  1  consumer pops head entry when rd_valid && rd_ready
- rd_valid  out  1  FIFO non-empty
- rd_data  out  8  head entry, valid while rd_valid
- level  out  FIFO_AW+1  current occupancy, 0..FIFO_DEPTH
- overrun  out  1  sticky: frame completed while FIFO full
- frame_err  out  1  sticky: stop bit sampled low
- clear_err  in  1  one-cycle pulse clears overrun and frame_err
- busy  out  1  high from start-bit detection to end of stop-bit sample

Behaviour:
- Reset (asynchronous, active-low):
  - state IDLE; FIFO pointers 0; level 0; rd_valid 0; rd_data 8'h00.
  - overrun 0; frame_err 0; busy 0; synchroniser flops preset to 1.
- rx passes through a 2-FF synchroniser; all decoding uses the synchronised copy rx_s.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_s==0 -> START; baud counter cleared.
  - START: count to CLKS_PER_BIT/2 (integer divide), then resample. rx_s==0 -> DATA with counter 0 and bit index 0. rx_s==1 -> glitch, return to IDLE; nothing written, no error flagged.
  - DATA: each CLKS_PER_BIT cycles sample rx_s into shift[bit_idx], LSB first. After bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles sample rx_s.
    - 1: byte is good; push if not full, else set overrun and discard the byte.
    - 0: set frame_err and discard the byte.
    - Either way, go to IDLE the following cycle.
    - A new start bit is accepted from IDLE immediately; back-to-back frames with no idle gap must be received.
- busy = (state != IDLE).
- FIFO:
  - Synchronous, first-word fall-through; rd_data reflects the head entry combinationally from the storage array.
  - Push occurs in the STOP sample cycle; pop occurs when rd_valid && rd_ready.
  - Simultaneous push and pop while full: pop frees a slot and the push succeeds; level unchanged; no overrun.
  - Simultaneous push and pop while empty: push succeeds, pop ignored (rd_valid was 0); level becomes 1.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are derived from level.
  - rd_ready while empty: no effect.
- Latency: a byte becomes visible (rd_valid rises) one cycle after the STOP sample cycle, about 9.5 bit-times after the start-bit falling edge (+2 synchroniser cycles).
- Error flags:
  - Sticky until a clear_err pulse.
  - A clear_err coinciding with a new error event: the set wins.
- Reset mid-frame aborts the frame immediately; the next start bit after reset is decoded normally.

Optional Feature:
- UART_RX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP sampling one even-parity bit. Mismatch sets a sticky parity_err output (1 bit, cleared by clear_err) and discards the byte; the stop-bit check still runs.
- Undefined: 8N1 only; the parity_err port does not exist.

Test Plan:
- Single byte 8'h00, then separately 8'hA5, driven at 4167 clks/bit -> rd_valid rises; rd_data equals the sent value; level=1; pop with rd_ready -> level=0, rd_valid=0.
- 17 back-to-back frames (bytes 0..16), no pops -> level=16; byte 16 dropped; overrun=1; popping yields 0..15 in order; clear_err -> overrun=0.
- Frame with stop bit forced low on byte 8'h3C -> frame_err=1; level unchanged; next good frame 8'h55 is received normally.
- 1-bit-time-short low glitch (CLKS_PER_BIT/4 cycles) on idle rx -> returns to IDLE; level=0; no error flags; busy pulses then falls.
- FIFO full plus a frame completing in the same cycle as rd_ready -> level stays 16; no overrun; popped order intact.
- rst_n asserted mid-DATA of byte 8'hFF, released, then 8'h81 sent -> only 8'h81 present; level=1; flags 0.
